tlb_op_ctrl: RTL and testbench

- Sequencer between the pipeline/CSR file and the TLB array for TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB.
- Accepts one TLB instruction at a time over a valid/ready handshake and drives the TLB write, read and invtlb ports.
- Arbitrates search port 1 between the load/store stage and its own TLBSRCH/INVTLB lookups, which need the s1 compare.
- Returns registered results for CSR update with a one-cycle done pulse.

---
 rtl/tlb_pkg.sv | 90 +++++++++
 rtl/tlb_s1_arb.sv | 45 ++++
 rtl/tlb_op_ctrl.sv | 171 +++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared TLB definitions: op codes, INVTLB ops, packed entry layout and the
// helper that assembles a write entry from the CSR images.
package tlb_pkg;

    typedef enum logic [2:0] {
        OP_SRCH = 3'd0,
        OP_RD   = 3'd1,
        OP_WR   = 3'd2,
        OP_FILL = 3'd3,
        OP_INV  = 3'd4
    } op_code_e;

    localparam logic [4:0] INV_ALL        = 5'd0;
    localparam logic [4:0] INV_ALL_1      = 5'd1;
    localparam logic [4:0] INV_G          = 5'd2;
    localparam logic [4:0] INV_NG         = 5'd3;
    localparam logic [4:0] INV_NG_ASID    = 5'd4;
    localparam logic [4:0] INV_NG_ASID_VA = 5'd5;
    localparam logic [4:0] INV_G_ASID_VA  = 5'd6;
    localparam logic [4:0] INV_OP_MAX     = INV_G_ASID_VA;

    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    // First field is the MSB; the offsets below mirror this order.
    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    localparam int ENTRY_W   = $bits(tlb_entry_t);
    localparam int V1_OFS    = 0;
    localparam int D1_OFS    = 1;
    localparam int MAT1_OFS  = 2;
    localparam int PLV1_OFS  = 4;
    localparam int PPN1_OFS  = 6;
    localparam int V0_OFS    = 26;
    localparam int D0_OFS    = 27;
    localparam int MAT0_OFS  = 28;
    localparam int PLV0_OFS  = 30;
    localparam int PPN0_OFS  = 32;
    localparam int G_OFS     = 52;
    localparam int ASID_OFS  = 53;
    localparam int PS_OFS    = 63;
    localparam int VPPN_OFS  = 69;
    localparam int E_OFS     = 88;

    function automatic tlb_entry_t make_entry(
        input logic [18:0] vppn,
        input logic [9:0]  asid,
        input logic [31:0] tlbidx,
        input logic [31:0] elo0,
        input logic [31:0] elo1,
        input logic [5:0]  ecode
    );
        tlb_entry_t ent;
        logic       unused_bits;
        unused_bits = ^{tlbidx[30], tlbidx[23:0], elo0[31:28], elo0[7], elo1[31:28], elo1[7]};
        // A refill exception always writes a valid entry regardless of NE.
        ent.e    = (ecode == ECODE_TLBR) ? 1'b1 : !tlbidx[31];
        ent.vppn = vppn;
        ent.ps   = tlbidx[29:24];
        ent.asid = asid;
        ent.g    = elo0[6] & elo1[6];
        ent.ppn0 = elo0[27:8];
        ent.plv0 = elo0[3:2];
        ent.mat0 = elo0[5:4];
        ent.d0   = elo0[1];
        ent.v0   = elo0[0];
        ent.ppn1 = elo1[27:8];
        ent.plv1 = elo1[3:2];
        ent.mat1 = elo1[5:4];
        ent.d1   = elo1[1];
        ent.v1   = elo1[0];
        return ent;
    endfunction

endpackage

// File: rtl/tlb_s1_arb.sv
// Search-port-1 arbiter: muxes the lookup key between the load/store stage and
// the controller, and counts how long the controller has yielded.
module tlb_s1_arb
    import tlb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_own,
    input  logic [18:0] ctrl_vppn,
    input  logic [9:0]  ctrl_asid,
    input  logic        mem_req,
    input  logic [18:0] mem_vppn,
    input  logic        mem_va_bit12,
    input  logic [9:0]  mem_asid,
    input  logic        stay_wait,
    output logic [18:0] s1_vppn,
    output logic        s1_va_bit12,
    output logic [9:0]  s1_asid,
    output logic        mem_gnt,
    output logic        starve_hit
);
    localparam int CW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

    logic [CW-1:0] starve_cnt;

    assign s1_vppn     = ctrl_own ? ctrl_vppn : mem_vppn;
    assign s1_va_bit12 = ctrl_own ? 1'b0      : mem_va_bit12;
    assign s1_asid     = ctrl_own ? ctrl_asid : mem_asid;
    assign mem_gnt     = mem_req && !ctrl_own;
    assign starve_hit  = (starve_cnt == CW'(STARVE_MAX - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (stay_wait) begin
            starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB instruction sequencer: accepts one TLB op, drives the TLB array ports for
// one EXEC cycle and returns registered results with a one-cycle done pulse.
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter  int TLBNUM     = 16,
    parameter  int STARVE_MAX = 4,
    localparam int IW         = $clog2(TLBNUM)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [2:0]         op_code,
    input  logic [4:0]         inv_op,
    input  logic [9:0]         inv_asid,
    input  logic [18:0]        inv_vppn,
    input  logic               flush,
    input  logic [18:0]        csr_vppn,
    input  logic [9:0]         csr_asid,
    input  logic [31:0]        csr_tlbidx,
    input  logic [31:0]        csr_tlbelo0,
    input  logic [31:0]        csr_tlbelo1,
    input  logic [5:0]         csr_ecode,
    input  logic               mem_s1_req,
    input  logic [18:0]        mem_s1_vppn,
    input  logic               mem_s1_va_bit12,
    input  logic [9:0]         mem_s1_asid,
    output logic               mem_s1_gnt,
    output logic [18:0]        tlb_s1_vppn,
    output logic               tlb_s1_va_bit12,
    output logic [9:0]         tlb_s1_asid,
    input  logic               tlb_s1_found,
    input  logic [IW-1:0]      tlb_s1_index,
    output logic               tlb_we,
    output logic [IW-1:0]      tlb_w_index,
    output logic [ENTRY_W-1:0] tlb_w_entry,
    output logic [IW-1:0]      tlb_r_index,
    input  logic [ENTRY_W-1:0] tlb_r_entry,
    output logic               tlb_invtlb_valid,
    output logic [4:0]         tlb_invtlb_op,
    output logic               done,
    output logic [2:0]         done_op,
    output logic               res_found,
    output logic [IW-1:0]      res_index,
    output logic [ENTRY_W-1:0] res_entry,
    output logic               res_ill
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT_S1, S_EXEC, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [2:0]    op_q;
    logic [4:0]    inv_op_q;
    logic [9:0]    inv_asid_q;
    logic [18:0]   inv_vppn_q;
    logic [IW-1:0] fill_ctr;
    logic          accept, needs_s1_in, needs_s1_q, in_exec, ctrl_own;
    logic          inv_legal, starve_hit, stay_wait;

    assign accept      = op_valid && (state_q == S_IDLE);
    assign needs_s1_in = (op_code == OP_SRCH) || (op_code == OP_INV);
    assign needs_s1_q  = (op_q == OP_SRCH) || (op_q == OP_INV);
    assign in_exec     = (state_q == S_EXEC);
    assign ctrl_own    = in_exec && needs_s1_q;
    assign inv_legal   = (inv_op_q <= INV_OP_MAX);
    assign stay_wait   = (state_q == S_WAIT_S1) && (state_d == S_WAIT_S1);

    tlb_s1_arb #(.STARVE_MAX(STARVE_MAX)) u_s1_arb (
        .clk          (clk),
        .reset        (reset),
        .ctrl_own     (ctrl_own),
        .ctrl_vppn    ((op_q == OP_INV) ? inv_vppn_q : csr_vppn),
        .ctrl_asid    ((op_q == OP_INV) ? inv_asid_q : csr_asid),
        .mem_req      (mem_s1_req),
        .mem_vppn     (mem_s1_vppn),
        .mem_va_bit12 (mem_s1_va_bit12),
        .mem_asid     (mem_s1_asid),
        .stay_wait    (stay_wait),
        .s1_vppn      (tlb_s1_vppn),
        .s1_va_bit12  (tlb_s1_va_bit12),
        .s1_asid      (tlb_s1_asid),
        .mem_gnt      (mem_s1_gnt),
        .starve_hit   (starve_hit)
    );

    assign op_ready      = (state_q == S_IDLE);
    assign done          = (state_q == S_DONE);
    assign done_op       = op_q;
    assign tlb_r_index   = csr_tlbidx[IW-1:0];
    assign tlb_invtlb_op = inv_op_q;
    assign tlb_w_entry   = make_entry(csr_vppn, csr_asid, csr_tlbidx,
                                      csr_tlbelo0, csr_tlbelo1, csr_ecode);

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_d          = state_q;
        tlb_we           = 1'b0;
        tlb_w_index      = fill_ctr;
        tlb_invtlb_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (needs_s1_in && mem_s1_req) ? S_WAIT_S1 : S_EXEC;
                end
            end
            S_WAIT_S1: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (!mem_s1_req || starve_hit) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_DONE;
                case (op_q)
                    OP_WR: begin
                        tlb_we      = 1'b1;
                        tlb_w_index = csr_tlbidx[IW-1:0];
                    end
                    OP_FILL: tlb_we = 1'b1;
                    OP_INV:  tlb_invtlb_valid = inv_legal;
                    default: ;
                endcase
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_vppn_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q       <= op_code;
                inv_op_q   <= inv_op;
                inv_asid_q <= inv_asid;
                inv_vppn_q <= inv_vppn;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_ctr <= '0;
        end else begin
            fill_ctr <= (fill_ctr == IW'(TLBNUM - 1)) ? '0 : fill_ctr + 1'b1;
        end
    end

    // Every completing op rewrites all results; fields unrelated to it read zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_found <= 1'b0;
            res_index <= '0;
            res_entry <= '0;
            res_ill   <= 1'b0;
        end else if (in_exec) begin
            res_found <= (op_q == OP_SRCH) && tlb_s1_found;
            res_index <= (op_q == OP_SRCH) ? tlb_s1_index : '0;
            res_entry <= ((op_q == OP_RD) && tlb_r_entry[E_OFS]) ? tlb_r_entry : '0;
            res_ill   <= (op_q == OP_INV) && !inv_legal;
        end
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a tiny TLB array model answering s1/read.
module tb_tlb_op_ctrl;
    import tlb_pkg::*;

    localparam int IW = 4;
    localparam logic [ENTRY_W-1:0] ENT2 = {1'b1, 88'h0123456789ABCDEF012345};
    localparam logic [ENTRY_W-1:0] ENT7 = {1'b0, 88'hFFFFFFFFFFFFFFFFFFFFFF};

    logic clk = 1'b0, reset = 1'b1;
    logic op_valid, op_ready, flush;
    logic [2:0] op_code, done_op;
    logic [4:0] inv_op, tlb_invtlb_op;
    logic [9:0] inv_asid, csr_asid, mem_s1_asid, tlb_s1_asid;
    logic [18:0] inv_vppn, csr_vppn, mem_s1_vppn, tlb_s1_vppn;
    logic [31:0] csr_tlbidx, csr_tlbelo0, csr_tlbelo1;
    logic [5:0] csr_ecode;
    logic mem_s1_req, mem_s1_va_bit12, mem_s1_gnt, tlb_s1_va_bit12, tlb_s1_found;
    logic [IW-1:0] tlb_s1_index, tlb_w_index, tlb_r_index, res_index;
    logic tlb_we, tlb_invtlb_valid, done, res_found, res_ill;
    logic [ENTRY_W-1:0] tlb_w_entry, tlb_r_entry, res_entry;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tlb_op_ctrl #(.TLBNUM(16), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn), .flush(flush),
        .csr_vppn(csr_vppn), .csr_asid(csr_asid), .csr_tlbidx(csr_tlbidx),
        .csr_tlbelo0(csr_tlbelo0), .csr_tlbelo1(csr_tlbelo1), .csr_ecode(csr_ecode),
        .mem_s1_req(mem_s1_req), .mem_s1_vppn(mem_s1_vppn), .mem_s1_va_bit12(mem_s1_va_bit12),
        .mem_s1_asid(mem_s1_asid), .mem_s1_gnt(mem_s1_gnt), .tlb_s1_vppn(tlb_s1_vppn),
        .tlb_s1_va_bit12(tlb_s1_va_bit12), .tlb_s1_asid(tlb_s1_asid), .tlb_s1_found(tlb_s1_found),
        .tlb_s1_index(tlb_s1_index), .tlb_we(tlb_we), .tlb_w_index(tlb_w_index),
        .tlb_w_entry(tlb_w_entry), .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
        .tlb_invtlb_valid(tlb_invtlb_valid), .tlb_invtlb_op(tlb_invtlb_op), .done(done),
        .done_op(done_op), .res_found(res_found), .res_index(res_index), .res_entry(res_entry),
        .res_ill(res_ill)
    );

    // Entry 5 holds vppn 0x12345 / asid 3; entry 2 is valid, entry 7 has e=0.
    always_comb begin
        tlb_s1_found = (tlb_s1_vppn == 19'h12345) && (tlb_s1_asid == 10'd3);
        tlb_s1_index = tlb_s1_found ? 4'd5 : 4'd0;
        case (tlb_r_index)
            4'd2:    tlb_r_entry = ENT2;
            4'd7:    tlb_r_entry = ENT7;
            default: tlb_r_entry = '0;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        op_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_op(input logic [2:0] code);
        op_code  = code;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (op_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b exp 1", op_ready); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b exp 0", done); end
        n_checks++; if ({tlb_we, tlb_invtlb_valid} !== 2'b00) begin n_errors++; $display("FAIL reset_strobes: got %b exp 00", {tlb_we, tlb_invtlb_valid}); end
        n_checks++; if ({res_found, res_index, res_ill} !== '0 || res_entry !== '0) begin n_errors++; $display("FAIL reset_res: found %b idx %0d ill %b entry %h", res_found, res_index, res_ill, res_entry); end
    endtask

    task automatic test_srch();
        csr_vppn = 19'h12345; csr_asid = 10'd3; mem_s1_req = 1'b0;
        start_op(OP_SRCH);
        n_checks++; if (op_ready !== 1'b0) begin n_errors++; $display("FAIL srch_busy: got %b exp 0", op_ready); end
        n_checks++; if ({tlb_s1_vppn, tlb_s1_asid, tlb_s1_va_bit12} !== {19'h12345, 10'd3, 1'b0}) begin n_errors++; $display("FAIL srch_key: got %h/%h/%b exp 12345/3/0", tlb_s1_vppn, tlb_s1_asid, tlb_s1_va_bit12); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL srch_early_done: got %b exp 0", done); end
        @(negedge clk);
        n_checks++; if ({done, done_op} !== {1'b1, 3'd0}) begin n_errors++; $display("FAIL srch_done: got %b/%0d exp 1/0", done, done_op); end
        n_checks++; if ({res_found, res_index} !== {1'b1, 4'd5}) begin n_errors++; $display("FAIL srch_hit: got %b/%0d exp 1/5", res_found, res_index); end
        @(negedge clk);
        n_checks++; if ({done, op_ready, res_found} !== 3'b011) begin n_errors++; $display("FAIL srch_after: done/ready/found %b exp 011", {done, op_ready, res_found}); end
        csr_asid = 10'd4;
        start_op(OP_SRCH);
        @(negedge clk);
        n_checks++; if ({done, res_found} !== 2'b10) begin n_errors++; $display("FAIL srch_miss: done/found %b exp 10", {done, res_found}); end
        @(negedge clk);
    endtask

    task automatic test_rd();
        csr_tlbidx = 32'd2;
        start_op(OP_RD);
        n_checks++; if (tlb_r_index !== 4'd2) begin n_errors++; $display("FAIL rd_index: got %0d exp 2", tlb_r_index); end
        @(negedge clk);
        n_checks++; if ({done, done_op} !== {1'b1, 3'd1} || res_entry !== ENT2) begin n_errors++; $display("FAIL rd_valid: done %b op %0d entry %h exp %h", done, done_op, res_entry, ENT2); end
        @(negedge clk);
        csr_tlbidx = 32'd7;
        start_op(OP_RD);
        @(negedge clk);
        n_checks++; if (done !== 1'b1 || res_entry !== '0) begin n_errors++; $display("FAIL rd_invalid: done %b entry %h exp 0", done, res_entry); end
        @(negedge clk);
    endtask

    task automatic test_wr();
        tlb_entry_t exp_e;
        csr_vppn = 19'h2AAAA; csr_asid = 10'h155; csr_tlbidx = 32'h0C00_0004;
        csr_tlbelo0 = 32'h0123_455F; csr_tlbelo1 = 32'h0ABC_DE61; csr_ecode = 6'h00;
        exp_e = '{e: 1'b1, vppn: 19'h2AAAA, ps: 6'd12, asid: 10'h155, g: 1'b1,
                  ppn0: 20'h12345, plv0: 2'd3, mat0: 2'd1, d0: 1'b1, v0: 1'b1,
                  ppn1: 20'hABCDE, plv1: 2'd0, mat1: 2'd2, d1: 1'b0, v1: 1'b1};
        start_op(OP_WR);
        n_checks++; if ({tlb_we, tlb_invtlb_valid, tlb_w_index} !== {2'b10, 4'd4}) begin n_errors++; $display("FAIL wr_strobe: we %b inv %b idx %0d exp 1/0/4", tlb_we, tlb_invtlb_valid, tlb_w_index); end
        n_checks++; if (tlb_w_entry !== exp_e) begin n_errors++; $display("FAIL wr_entry: got %h exp %h", tlb_w_entry, exp_e); end
        @(negedge clk);
        n_checks++; if ({tlb_we, done, done_op} !== {2'b01, 3'd2}) begin n_errors++; $display("FAIL wr_done: we %b done %b op %0d exp 0/1/2", tlb_we, done, done_op); end
        @(negedge clk);
    endtask

    task automatic fill_at(input int n, input logic [3:0] exp_idx, input logic [5:0] ecode, input logic exp_e);
        tlb_entry_t got;
        csr_ecode = ecode; csr_tlbidx = 32'h8C00_0001;
        csr_tlbelo0 = 32'h0000_0041; csr_tlbelo1 = 32'h0000_0001;
        do_reset();
        repeat (n - 1) @(negedge clk);
        start_op(OP_FILL);
        got = tlb_entry_t'(tlb_w_entry);
        n_checks++; if ({tlb_we, tlb_w_index} !== {1'b1, exp_idx}) begin n_errors++; $display("FAIL fill_idx_%0d: we %b idx %0d exp 1/%0d", n, tlb_we, tlb_w_index, exp_idx); end
        n_checks++; if ({got.e, got.g} !== {exp_e, 1'b0}) begin n_errors++; $display("FAIL fill_eg_%0d: e/g %b exp %b0", n, {got.e, got.g}, exp_e); end
        @(negedge clk);
        n_checks++; if ({tlb_we, done} !== 2'b01) begin n_errors++; $display("FAIL fill_done_%0d: we/done %b exp 01", n, {tlb_we, done}); end
        @(negedge clk);
    endtask

    task automatic test_fill();
        fill_at(9, 4'd9, ECODE_TLBR, 1'b1);
        fill_at(15, 4'd15, 6'h00, 1'b0);
        fill_at(16, 4'd0, ECODE_TLBR, 1'b1);
    endtask

    task automatic test_flush();
        mem_s1_req = 1'b1; mem_s1_vppn = 19'h70F0F; mem_s1_asid = 10'h2A; mem_s1_va_bit12 = 1'b1;
        start_op(OP_SRCH);
        n_checks++; if ({op_ready, mem_s1_gnt} !== 2'b01) begin n_errors++; $display("FAIL flush_wait: ready/gnt %b exp 01", {op_ready, mem_s1_gnt}); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; mem_s1_req = 1'b0;
        n_checks++; if (op_ready !== 1'b1) begin n_errors++; $display("FAIL flush_idle: ready %b exp 1", op_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if ({done, tlb_we, tlb_invtlb_valid} !== 3'b000) begin n_errors++; $display("FAIL flush_quiet: done/we/inv %b exp 000", {done, tlb_we, tlb_invtlb_valid}); end
        end
    endtask

    task automatic test_inv_starve();
        mem_s1_req = 1'b1; inv_op = 5'd5; inv_vppn = 19'h11111; inv_asid = 10'h3C;
        start_op(OP_INV);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if ({mem_s1_gnt, tlb_invtlb_valid, done, tlb_s1_vppn} !== {3'b100, 19'h70F0F}) begin n_errors++; $display("FAIL inv_wait_%0d: gnt %b inv %b done %b vppn %h exp 1/0/0/70f0f", i, mem_s1_gnt, tlb_invtlb_valid, done, tlb_s1_vppn); end
            @(negedge clk);
        end
        n_checks++; if ({tlb_invtlb_valid, tlb_invtlb_op, mem_s1_gnt, tlb_we} !== {1'b1, 5'd5, 2'b00}) begin n_errors++; $display("FAIL inv_exec: inv %b op %0d gnt %b we %b exp 1/5/0/0", tlb_invtlb_valid, tlb_invtlb_op, mem_s1_gnt, tlb_we); end
        n_checks++; if ({tlb_s1_vppn, tlb_s1_asid, tlb_s1_va_bit12} !== {19'h11111, 10'h3C, 1'b0}) begin n_errors++; $display("FAIL inv_key: got %h/%h/%b exp 11111/3c/0", tlb_s1_vppn, tlb_s1_asid, tlb_s1_va_bit12); end
        @(negedge clk);
        n_checks++; if ({done, done_op, res_ill} !== {1'b1, 3'd4, 1'b0}) begin n_errors++; $display("FAIL inv_done: done %b op %0d ill %b exp 1/4/0", done, done_op, res_ill); end
        mem_s1_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_inv_ill(input logic [4:0] op, input logic exp_strobe);
        inv_op = op;
        start_op(OP_INV);
        n_checks++; if ({tlb_invtlb_valid, tlb_we} !== {exp_strobe, 1'b0}) begin n_errors++; $display("FAIL inv_op%0d_strobe: inv/we %b exp %b0", op, {tlb_invtlb_valid, tlb_we}, exp_strobe); end
        @(negedge clk);
        n_checks++; if ({done, res_ill} !== {1'b1, !exp_strobe}) begin n_errors++; $display("FAIL inv_op%0d_ill: done/ill %b exp 1%b", op, {done, res_ill}, !exp_strobe); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        csr_tlbidx = 32'd2; op_code = OP_RD; op_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        op_valid = 1'b0;
        n_checks++; if (dones !== 3) begin n_errors++; $display("FAIL b2b_rate: got %0d dones exp 3", dones); end
        n_checks++; if (op_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready: got %b exp 1", op_ready); end
        @(negedge clk);
    endtask

    task automatic test_reset_exec();
        csr_tlbidx = 32'd3; csr_ecode = 6'h00;
        start_op(OP_WR);
        n_checks++; if (tlb_we !== 1'b1) begin n_errors++; $display("FAIL rexec_we: got %b exp 1", tlb_we); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({tlb_we, op_ready} !== 2'b01) begin n_errors++; $display("FAIL rexec_async: we/ready %b exp 01", {tlb_we, op_ready}); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if ({done, tlb_we, op_ready} !== 3'b001) begin n_errors++; $display("FAIL rexec_after: done/we/ready %b exp 001", {done, tlb_we, op_ready}); end
        end
    endtask

    initial begin
        op_valid = 1'b0; op_code = '0; inv_op = '0; inv_asid = '0; inv_vppn = '0; flush = 1'b0;
        csr_vppn = '0; csr_asid = '0; csr_tlbidx = '0; csr_tlbelo0 = '0; csr_tlbelo1 = '0;
        csr_ecode = '0; mem_s1_req = 1'b0; mem_s1_vppn = 19'h70F0F; mem_s1_va_bit12 = 1'b1;
        mem_s1_asid = 10'h2A;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_srch();
        test_rd();
        test_wr();
        test_fill();
        test_flush();
        test_inv_starve();
        test_inv_ill(5'd6, 1'b1);
        test_inv_ill(5'd7, 1'b0);
        test_back_to_back();
        test_reset_exec();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
